// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit multiplexed display controller.
package disp_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [5:0] DIGIT_E    = 6'd10;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;
  localparam int         CONV_STEPS = 14;
  localparam int         MAX_DEC    = 9999;

  // Double-dabble correction applied to one BCD nibble before each shift.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/leddisplay.sv
// Seven-segment decoder: 6-bit digit code to active-low segments {g,f,e,d,c,b,a}.
module leddisplay (
  input  logic [5:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (code)
      6'd0:    seg = 7'b1000000;
      6'd1:    seg = 7'b1111001;
      6'd2:    seg = 7'b0100100;
      6'd3:    seg = 7'b0110000;
      6'd4:    seg = 7'b0011001;
      6'd5:    seg = 7'b0010010;
      6'd6:    seg = 7'b0000010;
      6'd7:    seg = 7'b1111000;
      6'd8:    seg = 7'b0000000;
      6'd9:    seg = 7'b0010000;
      6'd10:   seg = 7'b0000110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Binary-to-BCD load path plus free-running digit scanner with blanking and blink.
// The scanner never waits on the converter; digits change only on commit.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] value,
  input  logic        blink_en,
  output logic        busy,
  output logic        done,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);
  localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [3:0]  STEP_LAST  = 4'(CONV_STEPS - 1);

  state_t           state_reg, state_next;
  logic             capture, shift_en, commit;

  logic [13:0]      bin_reg;
  logic [15:0]      bcd_reg;
  logic [15:0]      bcd_adj;
  logic [3:0]       step_reg;
  logic             over_reg;
  logic [3:0][3:0]  digit_reg;
  logic [3:0]       blank;

  logic [19:0]      presc_reg;
  logic             scan_tick;
  logic             frame_end;
  logic [1:0]       idx_reg;
  logic [7:0]       frame_reg;
  logic             phase_reg;
  logic [3:0]       an_reg;
  logic [6:0]       seg_reg;
  logic [5:0]       dec_code;
  logic [6:0]       dec_seg;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    shift_en   = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          capture    = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (step_reg == STEP_LAST) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        busy       = 1'b1;
        done       = 1'b1;
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------- double-dabble datapath ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = add3(bcd_reg[gi*4 +: 4]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      step_reg <= '0;
      over_reg <= 1'b0;
    end else if (capture) begin
      bin_reg  <= value;
      bcd_reg  <= '0;
      step_reg <= '0;
      over_reg <= (32'(value) > MAX_DEC);
    end else if (shift_en) begin
      bcd_reg  <= {bcd_adj[14:0], bin_reg[13]};
      bin_reg  <= {bin_reg[12:0], 1'b0};
      step_reg <= step_reg + 4'd1;
    end
  end

  // Out-of-range values show "E" everywhere; E is nonzero so nothing blanks.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        digit_reg[gi] <= 4'd0;
      end else if (commit) begin
        digit_reg[gi] <= over_reg ? DIGIT_E[3:0] : bcd_reg[gi*4 +: 4];
      end
    end
  end

  // A digit blanks when it and everything to its left is zero.
  assign blank[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_blank
    assign blank[gi] = (digit_reg[3:gi] == '0);
  end

  // ---------------- scan prescaler and digit index ----------------
  assign scan_tick = (presc_reg == PRESC_LAST);
  assign frame_end = scan_tick && (idx_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (scan_tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 20'd1;
    end
  end

  assign dec_code = {2'b00, digit_reg[idx_reg]};

  leddisplay u_dec (
    .code (dec_code),
    .seg  (dec_seg)
  );

  // idx_reg names the slot shown at the next tick, so reset shows digit 0 first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg <= 2'd0;
      an_reg  <= AN_OFF;
      seg_reg <= SEG_OFF;
    end else if (scan_tick) begin
      idx_reg <= idx_reg + 2'd1;
      seg_reg <= dec_seg;
      an_reg  <= (blank[idx_reg] || !phase_reg) ? AN_OFF : ~(4'b0001 << idx_reg);
    end
  end

  // ---------------- blink phase ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_reg <= '0;
      phase_reg <= 1'b1;
    end else if (!blink_en) begin
      frame_reg <= '0;
      phase_reg <= 1'b1;
    end else if (frame_end) begin
      if (frame_reg == FRAME_LAST) begin
        frame_reg <= '0;
        phase_reg <= ~phase_reg;
      end else begin
        frame_reg <= frame_reg + 8'd1;
      end
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed plus randomized bench for disp_scan_ctrl with an arithmetic display model.
module tb_disp_scan_ctrl;

  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [13:0] value;
  logic        blink_en;
  logic        busy;
  logic        done;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  // model state
  int   cyc = 0;
  bit   conv_on = 0;
  int   conv_start = 0;
  int   conv_val = 0;
  int   disp_val = 0;
  int   frames = 0;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic exp_busy = 0;
  logic exp_done = 0;

  disp_scan_ctrl #(
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .blink_en (blink_en),
    .busy     (busy),
    .done     (done),
    .an       (an),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0000110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int pow10(input int s);
    int p = 1;
    for (int i = 0; i < s; i++) p = p * 10;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later.
  task automatic clk_step();
    int  s;
    int  d;
    bit  tick;
    bit  commit_now;
    bit  blanked;
    bit  phase_on;
    @(posedge clk);
    if (!rst_n) begin
      cyc = 0; conv_on = 0; disp_val = 0; frames = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_busy = 0; exp_done = 0;
    end else begin
      cyc++;
      commit_now = 0;
      s = 0;
      if (conv_on && cyc == conv_start + 15) begin
        commit_now = 1;
        conv_on = 0;
      end else if (!conv_on && load) begin
        conv_on = 1;
        conv_start = cyc;
        conv_val = int'(value);
      end
      exp_busy = conv_on;
      exp_done = conv_on && (cyc == conv_start + 14);
      tick = (cyc % SD) == 0;
      if (tick) begin
        s = ((cyc / SD) - 1) % 4;
        phase_on = ((frames / BF) % 2) == 0;
        d = (disp_val > 9999) ? 10 : (disp_val / pow10(s)) % 10;
        blanked = (disp_val <= 9999) && (s > 0) && (disp_val < pow10(s));
        exp_seg = seg_of(d);
        exp_an = (blanked || !phase_on) ? 4'hF : ~(4'b0001 << s);
      end
      if (!blink_en) frames = 0;
      else if (tick && s == 3) frames++;
      if (commit_now) disp_val = conv_val;
    end
    #1;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_step();
  endtask

  task automatic do_load(input int v);
    value = 14'(v);
    load = 1'b1;
    clk_step();
    load = 1'b0;
    value = 14'($urandom_range(0, 16383));
    $display("load value=%0d at cyc=%0d", v, cyc);
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    value = '0;
    blink_en = 1'b0;

    // reset state and first scan showing "0"
    run(3);
    rst_n = 1'b1;
    run(20);

    do_load(1234);
    run(50);
    do_load(7);
    run(40);
    do_load(10000);
    run(40);

    // second load while busy is ignored
    done_cnt = 0;
    do_load(42);
    run(4);
    value = 14'd99;
    load = 1'b1;
    clk_step();
    load = 1'b0;
    run(40);
    chk("one_done", 32'(done_cnt), 32'd1);
    $display("overlap load: done pulses=%0d", done_cnt);

    // blink
    blink_en = 1'b1;
    do_load(8);
    run(160);
    blink_en = 1'b0;
    run(24);
    $display("blink sequence complete at cyc=%0d", cyc);

    // reset in the middle of a conversion
    done_cnt = 0;
    do_load(5555);
    run(6);
    rst_n = 1'b0;
    clk_step();
    clk_step();
    rst_n = 1'b1;
    run(30);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    do_load(5555);
    run(40);
    chk("reload_done", 32'(done_cnt), 32'd1);
    $display("abort/reload: done pulses=%0d", done_cnt);

    // randomized loads, values and blink toggles
    for (int i = 0; i < 800; i++) begin
      load = ($urandom_range(0, 19) == 0);
      value = 14'($urandom_range(0, 16383) >> $urandom_range(0, 13));
      if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
      clk_step();
      if (load && done === 1'b0 && !exp_busy) ;
      if (done === 1'b1) $display("random commit value=%0d at cyc=%0d", conv_val, cyc);
    end
    load = 1'b0;
    blink_en = 1'b0;
    run(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
